// File: rtl/register_file_32x32_if.sv
// Register file access bus: read/write strobes, addresses and data.
// master drives requests, slave (the register file) returns read data.
interface register_file_32x32_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  READ;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] ADDR_R1;
  logic [ADDR_WIDTH-1:0] ADDR_R2;
  logic [ADDR_WIDTH-1:0] ADDR_W;
  logic [DATA_WIDTH-1:0] DATA_W;
  logic [DATA_WIDTH-1:0] DATA_R1;
  logic [DATA_WIDTH-1:0] DATA_R2;

  modport master (
    output READ,
    output WRITE,
    output ADDR_R1,
    output ADDR_R2,
    output ADDR_W,
    output DATA_W,
    input  DATA_R1,
    input  DATA_R2
  );

  modport slave (
    input  READ,
    input  WRITE,
    input  ADDR_R1,
    input  ADDR_R2,
    input  ADDR_W,
    input  DATA_W,
    output DATA_R1,
    output DATA_R2
  );

endinterface

// File: rtl/register_file_32x32.sv
// 32x32 register file: two registered read ports, one write port, r0 = 0.
// Define REGFILE_WRITE_BYPASS_EN for write-through on read/write collisions.
module register_file_32x32 #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h03FF_FFFF
) (
  input logic                   CLK,
  input logic                   RESET,
  register_file_32x32_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0]   dec_w;
  logic [NUM_REGS-1:0]   load;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd2_d;
  logic [DATA_WIDTH-1:0] data_r1_q;
  logic [DATA_WIDTH-1:0] data_r2_q;

  // One-hot write address decoder
  always_comb begin
    dec_w = '0;
    dec_w[bus.ADDR_W] = 1'b1;
  end

  // Per-register load strobe; r0 never loads
  assign load = dec_w
              & {NUM_REGS{bus.WRITE}}
              & {{(NUM_REGS-1){1'b1}}, 1'b0};

  // Loaded registers take write data, others recirculate
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = load[i] ? bus.DATA_W : regs_q[i];
    end
    regs_d[0] = '0;
  end

  // Register array; SP comes out of reset non-zero
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // 32:1 read select with optional same-edge write forwarding
  function automatic logic [DATA_WIDTH-1:0] rd_sel(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] v;
    v = (a == '0) ? '0 : regs_q[a];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.WRITE && (a != '0) && (a == bus.ADDR_W)) begin
      v = bus.DATA_W;
    end
`endif
    return v;
  endfunction

  // Port 1 read mux
  always_comb begin
    rd1_d = rd_sel(bus.ADDR_R1);
  end

  // Port 2 read mux
  always_comb begin
    rd2_d = rd_sel(bus.ADDR_R2);
  end

  // Output latches: capture on READ, hold otherwise
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_r1_q <= '0;
      data_r2_q <= '0;
    end else if (bus.READ) begin
      data_r1_q <= rd1_d;
      data_r2_q <= rd2_d;
    end
  end

  assign bus.DATA_R1 = data_r1_q;
  assign bus.DATA_R2 = data_r2_q;

endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- 32-entry x 32-bit general-purpose register file for the DaVinci datapath.
- Sits directly downstream of the common logic library:
  - the write decoder drives per-register LOAD strobes into 32-bit registers;
  - read paths select through 32:1 multiplexers into output latches.
- Provides two registered read ports and one write port, sampled on the rising edge of CLK.
- Feeds operands to the ALU stage and receives writeback data from it.

Parameters:
- DATA_WIDTH, 32, bit width of every register and data port.
- ADDR_WIDTH, 5, width of every address port; NUM_REGS = 2**ADDR_WIDTH.
- SP_INDEX, 29, index of the stack-pointer register that resets to a non-zero pattern.
- SP_RESET, 32'h03FFFFFF, reset value loaded into register SP_INDEX.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset (RESET=0 resets immediately, independent of CLK).
- READ  input  1  read strobe; sample both read addresses this edge.
- WRITE  input  1  write strobe; commit DATA_W to ADDR_W this edge.
- ADDR_R1  input  ADDR_WIDTH  read port 1 address.
- ADDR_R2  input  ADDR_WIDTH  read port 2 address.
- ADDR_W  input  ADDR_WIDTH  write address.
- DATA_W  input  DATA_WIDTH  write data.
- DATA_R1  output  DATA_WIDTH  registered read data, port 1.
- DATA_R2  output  DATA_WIDTH  registered read data, port 2.

Behaviour:
- Reset (RESET=0, asynchronous):
  - all registers clear to 0, except register SP_INDEX, which takes SP_RESET;
  - DATA_R1 and DATA_R2 clear to 0;
  - strobes are ignored while RESET=0.
- Reset release:
  - the first rising edge with RESET=1 is a normal operating edge;
  - reset asserted mid-cycle overrides any in-progress write or read; no partial update survives.
- Register 0 is hardwired to zero:
  - writes to address 0 are discarded;
  - reads of address 0 return 0.
- Write (WRITE=1 at rising edge, ADDR_W != 0):
  - reg[ADDR_W] <= DATA_W;
  - the new value is visible to a read sampled on the next edge or later.
- Read (READ=1 at rising edge):
  - DATA_R1 <= reg[ADDR_R1] and DATA_R2 <= reg[ADDR_R2];
  - latency is 1 cycle, with data valid after the sampling edge;
  - ADDR_R1 == ADDR_R2 is legal and both ports return the same value.
- READ=0: DATA_R1 and DATA_R2 hold their last values indefinitely; no register change is caused by the read side.
- WRITE=0: no register changes.
- READ=1 and WRITE=1 on the same edge:
  - both operations occur;
  - a read whose address matches ADDR_W returns the pre-write (old) value, unless the optional feature is enabled.
- Addresses are unsigned with no wrap logic; every ADDR_WIDTH-bit value maps to exactly one register.
- Write-path structure: decoder output AND WRITE gives the per-register LOAD; non-selected registers recirculate their value.
- No combinational path from any input to DATA_R1 or DATA_R2.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - on an edge with READ=1, WRITE=1 and ADDR_Rn == ADDR_W != 0, DATA_Rn <= DATA_W (write-through forwarding);
  - address 0 is never bypassed and still returns 0.
- Undefined:
  - on such a collision, DATA_Rn <= the old register contents;
  - the stored register is still updated with DATA_W.
- The register array contents are identical in both builds; only the simultaneous-collision read value differs.

Test Plan:
- Reset check: assert RESET=0 for 2 cycles, release, then read addr 0/29 and addr 5/31 -> DATA_R1=0, DATA_R2=32'h03FFFFFF, then DATA_R1=0, DATA_R2=0.
- Write/read-back: write 32'hDEADBEEF to 7, then 32'h12345678 to 31; next cycle read 7/31 -> DATA_R1=32'hDEADBEEF, DATA_R2=32'h12345678 one cycle after the READ edge.
- R0 protection and hold: write 32'hFFFFFFFF to 0; read 0/0 -> both outputs 0. Then hold READ=0 for 3 cycles while changing addresses -> outputs unchanged.
- Collision: reg 4 = 32'hAAAA0000; same edge WRITE 32'h5555FFFF to 4 and READ 4/4 -> outputs 32'hAAAA0000 without macro, 32'h5555FFFF with REGFILE_WRITE_BYPASS_EN. Following read of 4 -> 32'h5555FFFF in both builds.
- Mid-operation reset: write 32'hCAFEF00D to 12; pull RESET low between edges -> DATA_R1/DATA_R2 go 0 immediately. After release, read 12/29 -> 0 and 32'h03FFFFFF.
- Full sweep: write value (i*32'h01010101) to every address 1..31, then read all pairs (i, 31-i) -> each port matches the expected value, and address 0 gives 0.
